// File: rtl/register_pkg.sv
// Shared types for the ready/valid register skid buffer.
package register_pkg;

  // Occupancy of the two-entry buffer: EMPTY (no word), BUSY (main holds a
  // word), FULL (main and skid both hold words, input side stalled).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/register_skid_buffer.sv
// Ready/valid pipeline register with a one-word skid slot.
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid && ready are both high on that interface. The producer may drop
// in_valid at any time without a transfer. Once out_valid is high, out_valid
// and out_data hold until the cycle out_ready is high. in_ready and out_valid
// are decoded from registered state only, so no input reaches any output
// combinationally and the ready path is fully registered.
//
// r_main always holds the word presented on out_data. r_skid catches the word
// accepted in the cycle the consumer stalls while main is occupied, which is
// what lets in_ready be registered without losing that word.
module register_skid_buffer
  import register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_accept;
  logic             w_deliver;

  // Transfers on each side, using the state-decoded handshake outputs.
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  // Outputs decoded from state only.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;

  // Occupancy state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) r_state <= BUSY;
        end
        BUSY: begin
          if (w_accept && !w_deliver)      r_state <= FULL;
          else if (!w_accept && w_deliver) r_state <= EMPTY;
        end
        FULL: begin
          if (w_deliver) r_state <= BUSY;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Main (output) register: loads new input when it becomes the head, or
  // the skid word when the head drains from FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) r_main <= in_data;
        end
        BUSY: begin
          if (w_accept && w_deliver) r_main <= in_data;
        end
        FULL: begin
          if (w_deliver) r_main <= r_skid;
        end
        default: r_main <= r_main;
      endcase
    end
  end

  // Skid register: captures the word accepted while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (r_state == BUSY && w_accept && !w_deliver) begin
      r_skid <= in_data;
    end
  end

endmodule

// File: tb/tb_register_skid_buffer.sv
// Self-checking bench for register_skid_buffer.
module tb_register_skid_buffer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int n_tot;
  int n_bad;

  logic [W-1:0] exp_q[$];

  // Values sampled in the current cycle, and the hold obligation from the
  // previous cycle.
  logic         s_ov;
  logic         s_ir;
  logic [W-1:0] s_od;
  logic         p_hold;
  logic [W-1:0] p_od;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ov;
    logic         e_ir;
    logic         od_care;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t vecs[14];

  register_skid_buffer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_data) && out_valid))
    else $error("FAIL a_hold: out_data/out_valid not held under backpressure");

  a_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !in_ready |-> out_valid)
    else $error("FAIL a_ready: in_ready low while out_valid low");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Driver plus scoreboard for one cycle: drive on negedge, sample 1 ns
  // later, then account for the transfers that the next posedge performs.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    s_ov = out_valid;
    s_ir = in_ready;
    s_od = out_data;
    if (p_hold) begin
      chk("hold_valid", 32'(s_ov), 32'd1);
      chk("hold_data", 32'(s_od), 32'(p_od));
    end
    if (!s_ir) chk("not_ready_needs_valid", 32'(s_ov), 32'd1);
    if (s_ov && ordy) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL deliver_unexpected: got %0h want none", s_od);
      end else begin
        chk("order", 32'(s_od), 32'(exp_q.pop_front()));
      end
    end
    if (iv && s_ir) exp_q.push_back(d);
    chk("depth_le_2", 32'(exp_q.size()), (exp_q.size() <= 2) ? 32'(exp_q.size()) : 32'd2);
    p_hold = s_ov && !ordy;
    p_od   = s_od;
  endtask

  initial begin
    n_tot  = 0;
    n_bad  = 0;
    p_hold = 1'b0;
    p_od   = '0;

    // Table: {iv, d, ordy, exp ov, exp ir, od care, exp od}; expected
    // outputs are those visible during the cycle the inputs are applied.
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[4]  = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[5]  = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
    vecs[6]  = '{1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77};
    vecs[9]  = '{1'b0, 8'h99, 1'b0, 1'b1, 1'b1, 1'b1, 8'h88};
    vecs[10] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h88};
    vecs[11] = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h88};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

    // Reset with a busy producer and stalled consumer.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("post_rst_out_data", 32'(out_data), 32'd0);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Directed vectors: backpressure to FULL, ignored input, drain, refill.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(s_ir), 32'(vecs[i].e_ir));
      if (vecs[i].od_care)
        chk($sformatf("vec%0d_out_data", i), 32'(s_od), 32'(vecs[i].e_od));
    end

    // Streaming at full rate with 1-cycle latency.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk("stream_in_ready", 32'(s_ir), 32'd1);
      if (i == 0) begin
        chk("stream_first_valid", 32'(s_ov), 32'd0);
      end else begin
        chk("stream_valid", 32'(s_ov), 32'd1);
        chk("stream_data", 32'(s_od), 32'(i - 1));
      end
    end
    step(1'b0, 8'h00, 1'b1);
    chk("stream_last_data", 32'(s_od), 32'd99);
    chk("stream_last_valid", 32'(s_ov), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("stream_empty", 32'(s_ov), 32'd0);

    // Mid-operation reset while FULL.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("midrst_full_in_ready", 32'(s_ir), 32'd0);
    chk("midrst_full_data", 32'(s_od), 32'h11);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    p_hold = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("midrst_no_word", 32'(s_ov), 32'd0);
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("random_all_delivered", 32'(exp_q.size()), 32'd0);
    chk("random_drained_valid", 32'(s_ov), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
